// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential divider.
package div_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, compare, subtract.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] new_rem,
    output logic             q_bit
);

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;

    // rem < divisor holds throughout a division, so trial < 2*divisor and the
    // difference always fits in WIDTH bits.
    always_comb begin
        trial   = {rem, next_bit};
        q_bit   = (trial >= {1'b0, divisor});
        diff    = trial[WIDTH-1:0] - divisor;
        new_rem = q_bit ? diff : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   state | meaning
//   IDLE  | waiting for start
//   CALC  | computing, one quotient bit per cycle
//   DONE  | results valid, done pulse; may accept a new start
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] new_rem;
    logic             q_bit;
    logic             accept;
    logic             last_step;

    assign accept    = start && (state_q != CALC);
    assign last_step = (state_q == CALC) && (cnt_q == CW'(1));

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .next_bit (dvd_q[WIDTH-1]),
        .divisor  (dvs_q),
        .new_rem  (new_rem),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d = (divisor == '0) ? DONE : CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The dividend register doubles as the quotient register: dividend bits
    // leave at the MSB while quotient bits enter at the LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt_q       <= CW'(WIDTH);
            dvd_q       <= dividend;
            dvs_q       <= divisor;
            rem_q       <= '0;
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state_q == CALC) begin
            cnt_q <= cnt_q - CW'(1);
            dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
            rem_q <= new_rem;
            if (last_step) begin
                quotient  <= {dvd_q[WIDTH-2:0], q_bit};
                remainder <= new_rem;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider against a plain-arithmetic division model.
module tb_seq_divider;

    localparam int W = 4;
    localparam int LIMIT = 40;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int errors = 0;
    int checks = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_q(input int a, input int b);
        return (b == 0) ? (1 << W) - 1 : a / b;
    endfunction

    function automatic int exp_r(input int a, input int b);
        return (b == 0) ? a : a % b;
    endfunction

    function automatic int exp_lat(input int b);
        return (b == 0) ? 1 : W + 1;
    endfunction

    // Called at a negedge; start is seen by the next posedge, returns one negedge later.
    task automatic issue(input int a, input int b);
        start    = 1'b1;
        dividend = W'(a);
        divisor  = W'(b);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges after the accepting edge until done is seen (bounded).
    task automatic wait_done(input int k0, output int lat, output int nbusy, output bit both);
        lat = k0;
        nbusy = 0;
        both = 1'b0;
        forever begin
            if (busy) nbusy++;
            if (busy && done) both = 1'b1;
            if (done || lat >= LIMIT) break;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b dbz=%b q=%0d r=%0d, want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic(input int a, input int b);
        int lat, nb;
        bit both;
        issue(a, b);
        wait_done(1, lat, nb, both);
        checks++;
        if (lat != exp_lat(b)) begin
            errors++;
            $display("FAIL basic_latency %0d/%0d: got %0d want %0d", a, b, lat, exp_lat(b));
        end
        checks++;
        if (nb != ((b == 0) ? 0 : W)) begin
            errors++;
            $display("FAIL basic_busy_cycles %0d/%0d: got %0d want %0d", a, b, nb, (b == 0) ? 0 : W);
        end
        checks++;
        if (both) begin
            errors++;
            $display("FAIL basic_busy_done_overlap %0d/%0d: got 1 want 0", a, b);
        end
        checks++;
        if (quotient !== W'(exp_q(a, b)) || remainder !== W'(exp_r(a, b))
            || div_by_zero !== (b == 0)) begin
            errors++;
            $display("FAIL basic_result %0d/%0d: got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b",
                     a, b, quotient, remainder, div_by_zero, exp_q(a, b), exp_r(a, b), b == 0);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, nb;
        bit both;
        issue(13, 3);
        @(negedge clk);
        start = 1'b1; dividend = 4'd9; divisor = 4'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done(3, lat, nb, both);
        checks++;
        if (lat != W + 1 || quotient !== 4'd4 || remainder !== 4'd1) begin
            errors++;
            $display("FAIL b2b_ignored_start: lat=%0d q=%0d r=%0d want lat=%0d q=4 r=1",
                     lat, quotient, remainder, W + 1);
        end
        issue(9, 2);
        lat = 1;
        while (!done && lat < LIMIT) begin
            checks++;
            if (quotient !== 4'd4 || remainder !== 4'd1) begin
                errors++;
                $display("FAIL b2b_hold: cycle %0d q=%0d r=%0d want q=4 r=1", lat, quotient, remainder);
            end
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != W + 1 || quotient !== 4'd4 || remainder !== 4'd1 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d q=%0d r=%0d dbz=%b want lat=%0d q=4 r=1 dbz=0",
                     lat, quotient, remainder, div_by_zero, W + 1);
        end
        @(negedge clk);
    endtask

    task automatic test_held_start();
        int k, last, n;
        start = 1'b1; dividend = 4'd6; divisor = 4'd4;
        k = 0; last = 0; n = 0;
        while (n < 3 && k < 3 * LIMIT) begin
            @(negedge clk);
            k++;
            if (done) begin
                n++;
                checks++;
                if (k - last != W + 1 || quotient !== 4'd1 || remainder !== 4'd2) begin
                    errors++;
                    $display("FAIL held_start #%0d: interval=%0d q=%0d r=%0d want %0d, q=1 r=2",
                             n, k - last, quotient, remainder, W + 1);
                end
                last = k;
            end
        end
        start = 1'b0;
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL held_start_count: got %0d dones want 3", n);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat, nb, seen;
        bit both;
        issue(12, 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: busy=%b done=%b dbz=%b q=%0d r=%0d want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_no_done: got %0d done pulses want 0", seen);
        end
        issue(12, 5);
        wait_done(1, lat, nb, both);
        checks++;
        if (lat != W + 1 || quotient !== 4'd2 || remainder !== 4'd2) begin
            errors++;
            $display("FAIL reset_mid_rerun: lat=%0d q=%0d r=%0d want lat=%0d q=2 r=2",
                     lat, quotient, remainder, W + 1);
        end
        @(negedge clk);
    endtask

    task automatic test_exhaustive();
        int lat, nb;
        bit both;
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                issue(a, b);
                wait_done(1, lat, nb, both);
                checks++;
                if (lat != exp_lat(b) || both) begin
                    errors++;
                    $display("FAIL exh_latency %0d/%0d: got %0d overlap=%b want %0d overlap=0",
                             a, b, lat, both, exp_lat(b));
                end
                checks++;
                if (quotient !== W'(exp_q(a, b)) || remainder !== W'(exp_r(a, b))
                    || div_by_zero !== (b == 0)) begin
                    errors++;
                    $display("FAIL exh_result %0d/%0d: got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b",
                             a, b, quotient, remainder, div_by_zero, exp_q(a, b), exp_r(a, b), b == 0);
                end
                if (b != 0) begin
                    checks++;
                    if (int'(quotient) * b + int'(remainder) != a || int'(remainder) >= b) begin
                        errors++;
                        $display("FAIL exh_identity %0d/%0d: q=%0d r=%0d violate q*b+r==a, r<b",
                                 a, b, quotient, remainder);
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int a, b, lat, pq, pr;
        pq = exp_q(15, 15);
        pr = exp_r(15, 15);
        for (int i = 0; i < 60; i++) begin
            a = $urandom_range(0, (1 << W) - 1);
            b = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, (1 << W) - 1);
            issue(a, b);
            lat = 1;
            while (!done && lat < LIMIT) begin
                checks++;
                if (quotient !== W'(pq) || remainder !== W'(pr)) begin
                    errors++;
                    $display("FAIL rand_hold #%0d: q=%0d r=%0d want q=%0d r=%0d",
                             i, quotient, remainder, pq, pr);
                end
                @(negedge clk);
                lat++;
            end
            checks++;
            if (lat != exp_lat(b) || quotient !== W'(exp_q(a, b)) || remainder !== W'(exp_r(a, b))
                || div_by_zero !== (b == 0)) begin
                errors++;
                $display("FAIL rand_result #%0d %0d/%0d: lat=%0d q=%0d r=%0d dbz=%b want lat=%0d q=%0d r=%0d dbz=%b",
                         i, a, b, lat, quotient, remainder, div_by_zero,
                         exp_lat(b), exp_q(a, b), exp_r(a, b), b == 0);
            end
            pq = exp_q(a, b);
            pr = exp_r(a, b);
            // Zero gap issues the next start in the DONE cycle.
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic(13, 3);
        test_basic(7, 0);
        test_basic(2, 9);
        test_basic(15, 1);
        test_back_to_back();
        test_held_start();
        test_reset_mid();
        test_exhaustive();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
